// File: rtl/shift_add_multiplier_if.sv
// ---------------------------------------------------------------------------
// shift_add_multiplier_if
//   Bundles the request/response signals of the shift-and-add multiplier.
//
//   Handshake: start is a level request that the multiplier samples only
//   while it is idle; a request seen in any other state is dropped, never
//   queued. Abus/Bbus are captured one cycle after start is accepted, so the
//   requester holds them stable through that cycle. done is a one-cycle
//   pulse. Pbus is valid from the done cycle on and holds that value until
//   the next done or a reset. busy is high while an operation is in flight.
//
//   Parameters: WIDTH - operand width (2..16)
//   Signals   : start (req), Abus/Bbus (operands), Pbus (2*WIDTH product),
//               busy, done
//   Modports  : master (requester), slave (multiplier)
// ---------------------------------------------------------------------------
interface shift_add_multiplier_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic [WIDTH-1:0]     Abus;
  logic [WIDTH-1:0]     Bbus;
  logic [2*WIDTH-1:0]   Pbus;
  logic                 busy;
  logic                 done;

  modport master (
    output start, Abus, Bbus,
    input  Pbus, busy, done
  );

  modport slave (
    input  start, Abus, Bbus,
    output Pbus, busy, done
  );
endinterface

// File: rtl/shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// shift_add_multiplier
//   Sequential unsigned shift-and-add multiplier. One CALC iteration per
//   multiplier bit: when the multiplier LSB is set the shifted multiplicand
//   is added to the accumulator, then the multiplicand shifts left and the
//   multiplier shifts right.
//
//   Optional feature (macro EARLY_TERM_EN): a CALC cycle that begins with
//   the remaining multiplier equal to zero ends the operation at once. The
//   product is the same either way; only latency shrinks.
//
//   Ports:
//     clk       - rising-edge clock
//     rst       - asynchronous, active-high reset
//     bus       - shift_add_multiplier_if.slave (start, Abus, Bbus, Pbus,
//                 busy, done)
//     state_dbg - current FSM state (IDLE=0, LOAD=1, CALC=2, DONE=3)
// ---------------------------------------------------------------------------
module shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  shift_add_multiplier_if.slave  bus,
  output logic [1:0]             state_dbg
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state;
  state_t               state_next;

  logic [2*WIDTH-1:0]   mreg;
  logic [WIDTH-1:0]     qreg;
  logic [2*WIDTH-1:0]   preg;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   pout;

  logic [2*WIDTH-1:0]   preg_add;
  logic                 last_iter;
  logic                 early_exit;

  // Accumulator value after this cycle's conditional add. Mreg is
  // zero-extended to 2*WIDTH, so the sum never exceeds the register.
  assign preg_add  = qreg[0] ? (preg + mreg) : preg;

  // cnt is about to decrement to zero: this is the final iteration.
  assign last_iter = (cnt == CNT_W'(1));

`ifdef EARLY_TERM_EN
  // No multiplier bits left: every further iteration would add nothing.
  assign early_exit = (qreg == '0);
`else
  assign early_exit = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // State register and datapath
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      mreg  <= '0;
      qreg  <= '0;
      preg  <= '0;
      cnt   <= '0;
      pout  <= '0;
    end else begin
      state <= state_next;
      case (state)
        LOAD: begin
          mreg <= {{WIDTH{1'b0}}, bus.Abus};
          qreg <= bus.Bbus;
          preg <= '0;
          cnt  <= CNT_W'(WIDTH);
        end
        CALC: begin
          if (early_exit) begin
            pout <= preg;
          end else begin
            preg <= preg_add;
            mreg <= mreg << 1;
            qreg <= qreg >> 1;
            cnt  <= cnt - CNT_W'(1);
            // Publish the result including this cycle's add.
            if (last_iter) pout <= preg_add;
          end
        end
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.start) state_next = LOAD;
      LOAD: state_next = CALC;
      CALC: if (early_exit || last_iter) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decode from state or come straight from registers, so there is
  // no combinational path from the request side to any output.
  assign bus.busy  = (state == LOAD) || (state == CALC);
  assign bus.done  = (state == DONE);
  assign bus.Pbus  = pout;
  assign state_dbg = state;

endmodule

// File: doc/shift_add_multiplier.md
# shift_add_multiplier

Sequential unsigned shift-and-add multiplier with a start/done handshake. It is the multiplication counterpart of the project's restoring divider. It accepts two WIDTH-bit operands and produces a 2·WIDTH-bit product after one iteration per multiplier bit. Controller and datapath live in one block and feed the same arithmetic test harness as the divider.

## Interface
- WIDTH, 8, operand width; legal range 2..16
- clk  input  1  rising-edge clock
- rst  input  1  reset: asynchronous, active-high; clock clk
- start  input  1  request; sampled only in IDLE
- Abus  input  WIDTH  multiplicand; captured in LOAD
- Bbus  input  WIDTH  multiplier; captured in LOAD
- Pbus  output  2·WIDTH  registered product; held until the next DONE
- busy  output  1  high in LOAD and CALC
- done  output  1  one-cycle pulse in DONE; Pbus is valid from this cycle on

## Operation
- Internal registers:
  - Mreg (2·WIDTH): multiplicand, zero-extended, shifts left.
  - Qreg (WIDTH): multiplier, shifts right.
  - Preg (2·WIDTH): accumulator.
  - cnt: width clog2(WIDTH+1).
  - Pout: drives Pbus.
- States: IDLE, LOAD, CALC, DONE.
- IDLE: start=1 → LOAD; otherwise stay. Outputs busy=0, done=0.
- LOAD (1 cycle): Mreg←{0,Abus}, Qreg←Bbus, Preg←0, cnt←WIDTH. Then → CALC. The operands are sampled at the LOAD edge, not the start edge.
- Each CALC cycle does:
  - If Qreg[0], Preg←Preg+Mreg. The addition is modulo 2^(2·WIDTH) and cannot overflow.
  - Mreg←Mreg<<1, Qreg←Qreg>>1, cnt←cnt−1.
  - Exit to DONE when the decremented cnt equals 0.
- CALC→DONE edge: Pout←final Preg, including that cycle's add.
- DONE (1 cycle): done=1, busy=0. Then → IDLE unconditionally.
- start while in LOAD, CALC or DONE: ignored, never queued. start held high through DONE begins a new operation on the first IDLE cycle.
- rst at any time:
  - State→IDLE; all registers, Pbus, busy and done →0.
  - An in-flight operation is discarded with no done pulse.
- Product equals Abus×Bbus, unsigned, exact in 2·WIDTH bits.

## Timing
- Edge E0 samples start=1 in IDLE. E1 completes LOAD. E2..E(WIDTH+1) run the CALC iterations.
- done=1 and the new Pbus appear after E(WIDTH+1), i.e. WIDTH+1 edges after E0.
- done falls after E(WIDTH+2). Back-to-back period is WIDTH+3 cycles, start to next start.
- busy rises after E0 and falls after E(WIDTH+1).
- Pbus changes only on the CALC→DONE edge and on reset.
- All outputs are registered or decoded from state only; there is no combinational path from start, Abus or Bbus to any output.

## Configuration
- EARLY_TERM_EN defined:
  - A CALC cycle that begins with Qreg==0 performs no add or shift and goes directly to DONE, with Pout←Preg.
  - Number of CALC cycles = 1 when Bbus=0, otherwise min(msb_index(Bbus)+2, WIDTH). done follows E0 by (CALC cycles + 1) edges.
- EARLY_TERM_EN undefined: always exactly WIDTH CALC cycles; Qreg==0 has no effect.
- The product value is identical in both builds.

## Test plan
- WIDTH=8, A=13, B=11, start one cycle → Pbus=0x008F. done pulses once, 9 edges after the start edge; busy is high for 9 cycles.
- A=255, B=255 → Pbus=0xFE01. Latency is 9 edges in both builds (B has bit 7 set).
- A=200, B=0 → Pbus=0x0000. done after 9 edges without EARLY_TERM_EN; after 2 edges with it. For A=7, B=1 with it: Pbus=0x0007, done after 3 edges.
- Start A=9, B=9, then pulse start with A=1, B=1 at edge 4 → the second pulse is ignored; Pbus=0x0051 and there is exactly one done.
- Start A=100, B=100, assert rst asynchronously at cycle 5 → busy, done and Pbus drop to 0 immediately, with no done pulse. A fresh start with A=3, B=5 yields Pbus=0x000F.
- Random sweep of 2000 operand pairs, start held high continuously → every done carries A×B. done spacing is WIDTH+3 cycles without EARLY_TERM_EN.
